// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared constants and types for the two-requester ALU arbiter
package alu_arb_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and shared-ALU signals of the arbiter
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) ();
    import alu_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_op;

    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [OP_W-1:0]           alu_ctrl;
    logic [DATA_W-1:0]         alu_result;
    logic                      alu_zero;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;
    logic                      rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_arb_pick.sv
// rtl/alu_arb_pick.sv - one-hot grant selection; ALU_ARB_RR_EN selects round-robin,
// otherwise fixed priority with requester 0 highest
module alu_arb_pick
    import alu_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant
`ifdef ALU_ARB_RR_EN
    ,
    input  logic               last_grant
`endif
);

`ifdef ALU_ARB_RR_EN
    // On contention the requester that did not win last time goes first
    always_comb begin
        grant = req_valid;
        if (&req_valid) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end
`else
    always_comb begin
        grant = '0;
        if (req_valid[0]) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters, one op in flight;
// ALU_ARB_RR_EN enables round-robin arbitration
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    state_t                r_state;
    logic                  r_gnt_id;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [OP_W-1:0]       r_op;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_result;
    logic                  r_rsp_zero;
    logic                  r_rsp_err;
`ifdef ALU_ARB_RR_EN
    logic                  r_last_grant;
`endif

    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_gnt_id;
    logic                  w_op_legal;

    alu_arb_pick u_pick (
        .req_valid (bus.req_valid),
        .grant     (w_grant)
`ifdef ALU_ARB_RR_EN
        ,
        .last_grant(r_last_grant)
`endif
    );

    assign w_gnt_id   = w_grant[1];
    assign w_op_legal = (r_op == OP_W'(ALU_ADD)) || (r_op == OP_W'(ALU_SUB));

    // Ready is offered combinationally in IDLE only, and never while reset is held
    assign bus.req_ready  = (r_state == ST_IDLE && !reset) ? w_grant : '0;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_ctrl   = r_op;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_err    = r_rsp_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_gnt_id     <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
`ifdef ALU_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_gnt_id <= w_gnt_id;
                        r_a      <= w_gnt_id ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
                        r_b      <= w_gnt_id ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
                        r_op     <= w_gnt_id ? bus.req_op[2*OP_W-1:OP_W]    : bus.req_op[OP_W-1:0];
`ifdef ALU_ARB_RR_EN
                        r_last_grant <= w_gnt_id;
`endif
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_result <= bus.alu_result;
                    r_rsp_zero   <= bus.alu_zero;
                    r_rsp_err    <= !w_op_legal;
                    r_rsp_valid  <= r_gnt_id ? 2'b10 : 2'b01;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's ready can complete the response
                    if (|(r_rsp_valid & bus.rsp_ready)) begin
                        r_rsp_valid <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    logic [1:0] exp_g [4];

    alu_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        bus.alu_result = '0;
        if (bus.alu_ctrl == 4'b0010) bus.alu_result = bus.alu_a + bus.alu_b;
        else if (bus.alu_ctrl == 4'b0110) bus.alu_result = bus.alu_a - bus.alu_b;
        bus.alu_zero = (bus.alu_a == bus.alu_b);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bus.req_a[r*DATA_W +: DATA_W] = a;
        bus.req_b[r*DATA_W +: DATA_W] = b;
        bus.req_op[r*OP_W +: OP_W]    = op;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
`ifdef ALU_ARB_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = '0;

        // reset values
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = 2'b01;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_rsp_result", 64'(bus.rsp_result), 64'h0);
        chk("rst_rsp_zero", 64'(bus.rsp_zero), 64'h0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'h0);
        chk("rst_alu_a", 64'(bus.alu_a), 64'h0);
        chk("rst_alu_b", 64'(bus.alu_b), 64'h0);
        chk("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'h0);
        bus.req_valid = '0;

        // requester 0: 5 + 3
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 32'd5, 32'd3, 4'b0010);
        bus.req_valid = 2'b01;
        #1;
        chk("add_req_ready_idle", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("add_req_ready_exec", 64'(bus.req_ready), 64'h0);
        chk("add_rsp_valid_exec", 64'(bus.rsp_valid), 64'h0);
        chk("add_alu_a", 64'(bus.alu_a), 64'd5);
        chk("add_alu_b", 64'(bus.alu_b), 64'd3);
        chk("add_alu_ctrl", 64'(bus.alu_ctrl), 64'h2);
        @(negedge clk);
        chk("add_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("add_rsp_result", 64'(bus.rsp_result), 64'd8);
        chk("add_rsp_zero", 64'(bus.rsp_zero), 64'h0);
        chk("add_rsp_err", 64'(bus.rsp_err), 64'h0);
        chk("add_req_ready_resp", 64'(bus.req_ready), 64'h0);
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        chk("add_rsp_done", 64'(bus.rsp_valid), 64'h0);
        bus.rsp_ready = '0;

        // requester 1: 7 - 7, response held with rsp_ready low
        set_req(1, 32'd7, 32'd7, 4'b0110);
        bus.req_valid = 2'b10;
        #1;
        chk("sub_req_ready_idle", 64'(bus.req_ready), 64'h2);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        chk("sub_rsp_valid", 64'(bus.rsp_valid), 64'h2);
        chk("sub_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("sub_rsp_zero", 64'(bus.rsp_zero), 64'h1);
        chk("sub_rsp_err", 64'(bus.rsp_err), 64'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sub_hold_valid", 64'(bus.rsp_valid), 64'h2);
            chk("sub_hold_result", 64'(bus.rsp_result), 64'd0);
            chk("sub_hold_zero", 64'(bus.rsp_zero), 64'h1);
        end
        bus.rsp_ready = 2'b10;
        @(negedge clk);
        chk("sub_rsp_done", 64'(bus.rsp_valid), 64'h0);
        bus.rsp_ready = '0;

        // illegal op, and wrong-requester ready must not complete
        set_req(0, 32'd1, 32'd2, 4'b0000);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        chk("ill_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("ill_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("ill_rsp_zero", 64'(bus.rsp_zero), 64'h0);
        chk("ill_rsp_err", 64'(bus.rsp_err), 64'h1);
        bus.rsp_ready = 2'b10;
        @(negedge clk);
        chk("other_ready_ignored_1", 64'(bus.rsp_valid), 64'h1);
        @(negedge clk);
        chk("other_ready_ignored_2", 64'(bus.rsp_valid), 64'h1);
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        chk("ill_rsp_done", 64'(bus.rsp_valid), 64'h0);
        bus.rsp_ready = '0;

        // reset while an operation is executing
        set_req(1, 32'd3, 32'd4, 4'b0010);
        bus.req_valid = 2'b10;
        @(negedge clk);
        bus.req_valid = '0;
        chk("rexec_in_exec", 64'(bus.alu_a), 64'd3);
        reset = 1'b1;
        #1;
        chk("rexec_rsp_valid_async", 64'(bus.rsp_valid), 64'h0);
        chk("rexec_alu_a_async", 64'(bus.alu_a), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rexec_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        @(negedge clk);
        chk("rexec_no_response", 64'(bus.rsp_valid), 64'h0);
        chk("rexec_alu_a_after", 64'(bus.alu_a), 64'h0);

        // both requesters continuously valid, immediately after reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 32'd10, 32'd1, 4'b0010);
        set_req(1, 32'd20, 32'd2, 4'b0110);
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("both_grant", 64'(bus.req_ready), 64'(exp_g[k]));
            @(negedge clk);
            chk("both_ready_exec", 64'(bus.req_ready), 64'h0);
            @(negedge clk);
            chk("both_rsp_valid", 64'(bus.rsp_valid), 64'(exp_g[k]));
            chk("both_rsp_result", 64'(bus.rsp_result), (exp_g[k] == 2'b01) ? 64'd11 : 64'd18);
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
